// File: rtl/ipml_prefetch_fifo_pkg.sv
// Shared helpers and parameter limits for the prefetch FIFO.
package ipml_prefetch_fifo_pkg;

   localparam int c_DATA_WIDTH_MIN  = 1;
   localparam int c_DATA_WIDTH_MAX  = 1152;
   localparam int c_DEPTH_WIDTH_MIN = 2;
   localparam int c_DEPTH_WIDTH_MAX = 20;
   localparam int c_RD_LAT_MIN      = 1;
   localparam int c_RD_LAT_MAX      = 2;

   // One output-buffer slot per RAM pipeline stage, plus the head slot.
   function automatic int f_ob_depth(input int lat);
      return lat + 1;
   endfunction

   function automatic int f_clog2(input int v);
      int r = 0;
      for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/ipml_pfifo_out_buf_v1_0.sv
// Output buffer of the prefetch FIFO: small register FIFO that absorbs every
// RAM read already issued, plus a credit counter (in-flight + held words)
// that decides whether another read may be issued.
module ipml_pfifo_out_buf_v1_0
   import ipml_prefetch_fifo_pkg::*;
#(
   parameter int c_DATA_WIDTH = 32,
   parameter int c_DEPTH      = 2
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_issue,
   input  logic                    i_wr_vld,
   input  logic [c_DATA_WIDTH-1:0] i_wr_data,
   input  logic                    i_rd_en,
   output logic                    o_rd_vld,
   output logic [c_DATA_WIDTH-1:0] o_rd_data,
   output logic                    o_pop,
   output logic                    o_can_issue
);

   localparam int PW = f_clog2(c_DEPTH);
   localparam int CW = f_clog2(c_DEPTH + 1);

   logic [c_DATA_WIDTH-1:0] r_buf [c_DEPTH];
   logic [PW-1:0]           r_wp, r_rp;
   logic [CW-1:0]           r_cnt, r_credit;
   logic                    w_pop;
   logic [PW-1:0]           w_last;

   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == PW'(c_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign o_rd_vld    = (r_cnt != '0);
   assign w_pop       = i_rd_en & o_rd_vld;
   assign o_pop       = w_pop;
   // When empty, show the slot just popped so the output holds its last value.
   assign w_last      = (r_rp == '0) ? PW'(c_DEPTH - 1) : r_rp - PW'(1);
   assign o_rd_data   = o_rd_vld ? r_buf[r_rp] : r_buf[w_last];
   // A pop this cycle frees a credit immediately, keeping 1 word/clk.
   assign o_can_issue = (r_credit - CW'(w_pop)) < CW'(c_DEPTH);

   // Buffer storage, pointers, occupancy and credit tracking
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < c_DEPTH; i++) r_buf[i] <= '0;
         r_wp     <= '0;
         r_rp     <= '0;
         r_cnt    <= '0;
         r_credit <= '0;
      end else begin
         if (i_wr_vld) begin
            r_buf[r_wp] <= i_wr_data;
            r_wp        <= f_inc(r_wp);
         end
         if (w_pop) r_rp <= f_inc(r_rp);
         r_cnt    <= r_cnt + CW'(i_wr_vld) - CW'(w_pop);
         r_credit <= r_credit + CW'(i_issue) - CW'(w_pop);
      end
   end

endmodule

// File: rtl/ipml_prefetch_fifo_v2_0.sv
// Single-clock first-word-fall-through FIFO: inferred RAM feeding a prefetch
// output buffer sized to the RAM read latency, with water level and
// almost-full/almost-empty flags.
// Optional macro IPML_PFIFO_OVF_CNT_EN adds o_ovf_cnt, a saturating count of
// dropped writes.
module ipml_prefetch_fifo_v2_0
   import ipml_prefetch_fifo_pkg::*;
#(
   parameter int c_DATA_WIDTH     = 32,
   parameter int c_DEPTH_WIDTH    = 10,
   parameter int c_RAM_RD_LATENCY = 1,
   parameter int c_AFULL_LEVEL    = 2**c_DEPTH_WIDTH - 4,
   parameter int c_AEMPTY_LEVEL   = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [c_DATA_WIDTH-1:0] i_wr_data,
   input  logic                    i_wr_en,
   output logic                    o_wr_vld,
   output logic                    o_almost_full,
   output logic [c_DATA_WIDTH-1:0] o_rd_data,
   input  logic                    i_rd_en,
   output logic                    o_rd_vld,
   output logic                    o_almost_empty,
   output logic [c_DEPTH_WIDTH:0]  o_water_level
`ifdef IPML_PFIFO_OVF_CNT_EN
  ,output logic [15:0]             o_ovf_cnt
`endif
);

   localparam int N     = c_DEPTH_WIDTH;
   localparam int LAT   = c_RAM_RD_LATENCY;
   localparam int D     = f_ob_depth(LAT);
   localparam int DEPTH = 2**N;
   localparam int CW    = N + 1;
   localparam logic [CW-1:0] c_AF    = CW'(c_AFULL_LEVEL);
   localparam logic [CW-1:0] c_AE    = CW'(c_AEMPTY_LEVEL);
   localparam logic [CW-1:0] c_FULL  = CW'(DEPTH);

   if (c_DATA_WIDTH < c_DATA_WIDTH_MIN || c_DATA_WIDTH > c_DATA_WIDTH_MAX ||
       c_DEPTH_WIDTH < c_DEPTH_WIDTH_MIN || c_DEPTH_WIDTH > c_DEPTH_WIDTH_MAX ||
       c_RAM_RD_LATENCY < c_RD_LAT_MIN || c_RAM_RD_LATENCY > c_RD_LAT_MAX) begin : g_bad_param
      $error("ipml_prefetch_fifo_v2_0: parameter out of range");
   end

   logic [c_DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [c_DATA_WIDTH-1:0] r_ram_q, w_ram_dout;
   logic [N-1:0]            r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]           r_ram_cnt, w_ram_cnt_nxt;
   logic [CW-1:0]           r_wl, w_wl_nxt;
   logic                    r_wr_vld, r_afull, r_aempty;
   logic                    w_wr_acc, w_issue, w_can_issue, w_pop;
   logic [LAT:1]            r_vld_pipe;
   logic [LAT:0]            w_vld_pipe;

   assign w_wr_acc      = i_wr_en & r_wr_vld;
   // Read needs ram_cnt>0, so it never targets the address being written.
   assign w_issue       = (r_ram_cnt != '0) & w_can_issue;
   assign w_vld_pipe    = {r_vld_pipe, w_issue};
   assign w_ram_cnt_nxt = r_ram_cnt + CW'(w_wr_acc) - CW'(w_issue);
   assign w_wl_nxt      = r_wl + CW'(w_wr_acc) - CW'(w_pop);

   // RAM write port and registered read port (no reset so it maps to block RAM)
   always_ff @(posedge i_clk) begin
      if (w_wr_acc) r_mem[r_wr_ptr] <= i_wr_data;
      if (w_issue)  r_ram_q         <= r_mem[r_rd_ptr];
   end

   if (LAT > 1) begin : g_ram_oreg
      logic [c_DATA_WIDTH-1:0] r_ram_oreg;
      // Optional RAM output register stage
      always_ff @(posedge i_clk) begin
         if (r_vld_pipe[1]) r_ram_oreg <= r_ram_q;
      end
      assign w_ram_dout = r_ram_oreg;
   end else begin : g_ram_noreg
      assign w_ram_dout = r_ram_q;
   end

   // Pointers, RAM count, write-ready, water level, flags and read pipeline
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_ram_cnt  <= '0;
         r_wr_vld   <= 1'b0;
         r_wl       <= '0;
         r_afull    <= 1'b0;
         r_aempty   <= 1'b1;
         r_vld_pipe <= '0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + N'(1);
         if (w_issue)  r_rd_ptr <= r_rd_ptr + N'(1);
         r_ram_cnt  <= w_ram_cnt_nxt;
         r_wr_vld   <= (w_ram_cnt_nxt != c_FULL);
         r_wl       <= w_wl_nxt;
         r_afull    <= (w_wl_nxt >= c_AF);
         r_aempty   <= (w_wl_nxt <= c_AE);
         r_vld_pipe <= w_vld_pipe[LAT-1:0];
      end
   end

   ipml_pfifo_out_buf_v1_0 #(
      .c_DATA_WIDTH (c_DATA_WIDTH),
      .c_DEPTH      (D)
   ) u_out_buf (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_issue     (w_issue),
      .i_wr_vld    (r_vld_pipe[LAT]),
      .i_wr_data   (w_ram_dout),
      .i_rd_en     (i_rd_en),
      .o_rd_vld    (o_rd_vld),
      .o_rd_data   (o_rd_data),
      .o_pop       (w_pop),
      .o_can_issue (w_can_issue)
   );

   assign o_wr_vld       = r_wr_vld;
   assign o_almost_full  = r_afull;
   assign o_almost_empty = r_aempty;
   assign o_water_level  = r_wl;

`ifdef IPML_PFIFO_OVF_CNT_EN
   logic [15:0] r_ovf_cnt;
   // Saturating count of writes dropped while not ready
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_ovf_cnt <= '0;
      else if (i_wr_en && !r_wr_vld && r_ovf_cnt != 16'hFFFF) r_ovf_cnt <= r_ovf_cnt + 16'd1;
   end
   assign o_ovf_cnt = r_ovf_cnt;
`endif

endmodule

// File: tb/tb_ipml_prefetch_fifo_v2_0.sv
// Bench: two instances (read latency 1 and 2) share one stimulus stream; each
// has its own scoreboard queue and water-level model checked at negedge.
`timescale 1ns/1ps
module tb_ipml_prefetch_fifo_v2_0;

   localparam int W = 16, N = 3, DEPTH = 8, AF = 6, AE = 2;

   logic         clk = 1'b0, rst_n = 1'b0;
   logic [W-1:0] wr_data = '0;
   logic         wr_en = 1'b0, rd_en = 1'b0;
   logic         wr_vld [2], rd_vld [2], afull [2], aempty [2];
   logic [W-1:0] rd_data [2];
   logic [N:0]   wl [2];
`ifdef IPML_PFIFO_OVF_CNT_EN
   logic [15:0]  ovf [2];
`endif
   int errs = 0, checks = 0;

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int LAT = g + 1;
      logic [W-1:0] q [$];
      int           wl_m, ovf_m;
      logic [W-1:0] last_m;

      ipml_prefetch_fifo_v2_0 #(
         .c_DATA_WIDTH(W), .c_DEPTH_WIDTH(N), .c_RAM_RD_LATENCY(LAT),
         .c_AFULL_LEVEL(AF), .c_AEMPTY_LEVEL(AE)
      ) u_dut (
         .i_clk(clk), .i_rst_n(rst_n), .i_wr_data(wr_data), .i_wr_en(wr_en),
         .o_wr_vld(wr_vld[g]), .o_almost_full(afull[g]), .o_rd_data(rd_data[g]),
         .i_rd_en(rd_en), .o_rd_vld(rd_vld[g]), .o_almost_empty(aempty[g]),
         .o_water_level(wl[g])
`ifdef IPML_PFIFO_OVF_CNT_EN
        ,.o_ovf_cnt(ovf[g])
`endif
      );

      // Monitor: compare head/level/flags against the model, then update it
      always @(negedge clk or negedge rst_n) begin
         if (!rst_n) begin
            q.delete();
            wl_m = 0; ovf_m = 0; last_m = '0;
         end else begin
            chk($sformatf("L%0d water_level", LAT), 32'(wl[g]), wl_m);
            chk($sformatf("L%0d almost_full", LAT), 32'(afull[g]), 32'(wl_m >= AF));
            chk($sformatf("L%0d almost_empty", LAT), 32'(aempty[g]), 32'(wl_m <= AE));
`ifdef IPML_PFIFO_OVF_CNT_EN
            chk($sformatf("L%0d ovf_cnt", LAT), 32'(ovf[g]), ovf_m);
`endif
            if (rd_vld[g]) begin
               if (q.size() == 0) chk($sformatf("L%0d rd_vld with empty model", LAT), 32'(rd_vld[g]), 0);
               else begin
                  chk($sformatf("L%0d rd_data head", LAT), 32'(rd_data[g]), 32'(q[0]));
                  last_m = q[0];
               end
            end else chk($sformatf("L%0d rd_data hold", LAT), 32'(rd_data[g]), 32'(last_m));
            if (wr_en && wr_vld[g]) q.push_back(wr_data);
            if (wr_en && !wr_vld[g] && ovf_m < 16'hFFFF) ovf_m++;
            if (rd_en && rd_vld[g]) void'(q.pop_front());
            wl_m = wl_m + 32'(wr_en && wr_vld[g]) - 32'(rd_en && rd_vld[g]);
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic check_reset(input string nm);
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("%s L%0d wr_vld", nm, g+1), 32'(wr_vld[g]), 0);
         chk($sformatf("%s L%0d rd_vld", nm, g+1), 32'(rd_vld[g]), 0);
         chk($sformatf("%s L%0d rd_data", nm, g+1), 32'(rd_data[g]), 0);
         chk($sformatf("%s L%0d water_level", nm, g+1), 32'(wl[g]), 0);
         chk($sformatf("%s L%0d almost_full", nm, g+1), 32'(afull[g]), 0);
         chk($sformatf("%s L%0d almost_empty", nm, g+1), 32'(aempty[g]), 1);
`ifdef IPML_PFIFO_OVF_CNT_EN
         chk($sformatf("%s L%0d ovf_cnt", nm, g+1), 32'(ovf[g]), 0);
`endif
      end
   endtask

   task automatic drain();
      int c = 0;
      wr_en = 1'b0; rd_en = 1'b1;
      while ((wl[0] != 0 || wl[1] != 0) && c < 100) begin tick(); c++; end
      rd_en = 1'b0;
      chk("drain within bound", 32'(c < 100), 1);
   endtask

   initial begin
      int gaps;
      // 1: reset and release
      #12;
      check_reset("reset");
      @(negedge clk); rst_n = 1'b1; #1;
      for (int g = 0; g < 2; g++) chk($sformatf("L%0d wr_vld before 1st edge", g+1), 32'(wr_vld[g]), 0);
      tick();
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("L%0d wr_vld after 1st edge", g+1), 32'(wr_vld[g]), 1);
         chk($sformatf("L%0d idle rd_vld", g+1), 32'(rd_vld[g]), 0);
      end

      // 2: single write latency
      wr_en = 1'b1; wr_data = 16'h0011; tick(); wr_en = 1'b0;   // accepted at edge T
      tick();                                                    // T+1
      chk("lat T+1 L1 rd_vld", 32'(rd_vld[0]), 0);
      chk("lat T+1 L2 rd_vld", 32'(rd_vld[1]), 0);
      tick();                                                    // T+2
      chk("lat T+2 L1 rd_vld", 32'(rd_vld[0]), 1);
      chk("lat T+2 L2 rd_vld", 32'(rd_vld[1]), 0);
      tick();                                                    // T+3
      chk("lat T+3 L2 rd_vld", 32'(rd_vld[1]), 1);
      for (int g = 0; g < 2; g++) chk($sformatf("L%0d first data", g+1), 32'(rd_data[g]), 32'h11);
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("L%0d rd_vld after pop", g+1), 32'(rd_vld[g]), 0);
         chk($sformatf("L%0d rd_data held", g+1), 32'(rd_data[g]), 32'h11);
      end

      // 3: fill to capacity, extra writes dropped
      for (int i = 0; i < 14; i++) begin wr_en = 1'b1; wr_data = W'(16'h100 + i); tick(); end
      wr_en = 1'b0;
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("L%0d full wr_vld", g+1), 32'(wr_vld[g]), 0);
         chk($sformatf("L%0d full almost_full", g+1), 32'(afull[g]), 1);
         chk($sformatf("L%0d full water_level", g+1), 32'(wl[g]), DEPTH + g + 2);
`ifdef IPML_PFIFO_OVF_CNT_EN
         chk($sformatf("L%0d dropped count", g+1), 32'(ovf[g]), 14 - (DEPTH + g + 2));
`endif
      end
      drain();

      // 4: streaming through three pointer wraps, no gaps
      gaps = 0;
      rd_en = 1'b1;
      for (int c = 0; c < 28; c++) begin
         wr_en = (c < 24); wr_data = W'(c);
         tick();
         if (c >= 3 && c <= 25 && !(rd_vld[0] && rd_vld[1])) gaps++;
      end
      wr_en = 1'b0;
      chk("stream gap cycles", 32'(gaps), 0);
      drain();

      // 5: random traffic, write-heavy then read-heavy
      for (int c = 0; c < 600; c++) begin
         if (c < 300) begin wr_en = ($urandom % 4) != 0; rd_en = ($urandom % 3) == 0; end
         else         begin wr_en = ($urandom % 3) == 0; rd_en = ($urandom % 4) != 0; end
         wr_data = W'($urandom);
         tick();
      end
      drain();

      // 6: asynchronous reset mid-stream
      for (int i = 0; i < 5; i++) begin wr_en = 1'b1; wr_data = W'(16'h200 + i); tick(); end
      wr_en = 1'b0;
      @(posedge clk); #2; rst_n = 1'b0; #1;
      check_reset("mid reset");
      @(negedge clk); rst_n = 1'b1;
      tick();
      wr_en = 1'b1; wr_data = 16'h005A; tick(); wr_en = 1'b0;
      repeat (4) tick();
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("L%0d post-reset rd_vld", g+1), 32'(rd_vld[g]), 1);
         chk($sformatf("L%0d post-reset first word", g+1), 32'(rd_data[g]), 32'h5A);
         chk($sformatf("L%0d post-reset level", g+1), 32'(wl[g]), 1);
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
